// File: rtl/decoder_pkg.sv
// Shared constants for the four-digit BCD scan decoder.
// The enable table is stored active-low; the top level inverts it when needed.
package decoder_pkg;

  localparam int DIGIT_COUNT = 4;
  localparam int NIBBLE_W    = 4;

  typedef logic [NIBBLE_W-1:0]    nibble_t;
  typedef logic [DIGIT_COUNT-1:0] digit_en_t;

  localparam digit_en_t DIGIT_OFF_AL = 4'b1111;

  localparam digit_en_t DIGIT_EN_AL [DIGIT_COUNT] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

endpackage

// File: rtl/decoder_digit_mux.sv
// Combinational 4:1 nibble select and leading-zero blank detection.
module digit_mux
  import decoder_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic [1:0]                    sel,
  input  logic [DIGIT_COUNT*NIBBLE_W-1:0] bcd,
  output nibble_t                       nibble,
  output logic                          blank
);

  logic [DIGIT_COUNT-1:0] zero_from;

  always_comb begin
    nibble = bcd[sel*NIBBLE_W +: NIBBLE_W];
    // zero_from[i]: digit i and every higher digit are zero
    for (int unsigned i = 0; i < DIGIT_COUNT; i++) begin
      zero_from[i] = 1'b1;
      for (int unsigned j = i; j < DIGIT_COUNT; j++) begin
        if (bcd[j*NIBBLE_W +: NIBBLE_W] != '0) zero_from[i] = 1'b0;
      end
    end
    blank = BLANK_LEADING && (sel != 2'd0) && zero_from[sel];
  end

endmodule

// File: rtl/decoder.sv
// Four-digit multiplexed display decoder: registers the scanned nibble and
// its one-hot digit enable with one cycle of latency.
module decoder
  import decoder_pkg::*;
#(
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  countout,
  input  logic [15:0] BCD,
  output logic [3:0]  LED_BCD,
  output logic [3:0]  digits
);

  nibble_t   sel_nibble;
  logic      sel_blank;
  digit_en_t en_al;
  digit_en_t off_pattern;

  nibble_t   led_bcd_d, led_bcd_q;
  digit_en_t digits_d,  digits_q;

  digit_mux #(
    .BLANK_LEADING(BLANK_LEADING)
  ) u_digit_mux (
    .sel    (countout),
    .bcd    (BCD),
    .nibble (sel_nibble),
    .blank  (sel_blank)
  );

  always_comb begin
    off_pattern = DIGIT_ACTIVE_LOW ? DIGIT_OFF_AL : ~DIGIT_OFF_AL;
    en_al       = sel_blank ? DIGIT_OFF_AL : DIGIT_EN_AL[countout];
    digits_d    = DIGIT_ACTIVE_LOW ? en_al : ~en_al;
    led_bcd_d   = sel_blank ? '0 : sel_nibble;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_bcd_q <= '0;
      digits_q  <= off_pattern;
    end else begin
      led_bcd_q <= led_bcd_d;
      digits_q  <= digits_d;
    end
  end

  assign LED_BCD = led_bcd_q;
  assign digits  = digits_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: three instances cover default polarity,
// leading-zero blanking, and active-high enables.
module tb_decoder;

  typedef struct {
    int         dut;
    logic [3:0] led;
    logic [3:0] dig;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic [1:0]  cnt   [3];
  logic [15:0] bcd   [3];
  logic [3:0]  led_o [3];
  logic [3:0]  dig_o [3];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  decoder u_dut0 (
    .clk(clk), .reset(rst[0]), .countout(cnt[0]), .BCD(bcd[0]),
    .LED_BCD(led_o[0]), .digits(dig_o[0])
  );

  decoder #(.DIGIT_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .countout(cnt[1]), .BCD(bcd[1]),
    .LED_BCD(led_o[1]), .digits(dig_o[1])
  );

  decoder #(.DIGIT_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) u_dut2 (
    .clk(clk), .reset(rst[2]), .countout(cnt[2]), .BCD(bcd[2]),
    .LED_BCD(led_o[2]), .digits(dig_o[2])
  );

  // Drive one instance for one cycle and queue what it must show after the edge.
  task automatic apply(input int d, input logic r, input logic [1:0] c,
                       input logic [15:0] b, input logic [3:0] led,
                       input logic [3:0] dig, input string name);
    exp_t e;
    rst[d] = r;
    cnt[d] = c;
    bcd[d] = b;
    e.dut = d; e.led = led; e.dig = dig; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so each edge presents one queued response.
  initial begin : monitor
    exp_t e;
    while (!stim_done || exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led_o[e.dut] !== e.led || dig_o[e.dut] !== e.dig) begin
          failures++;
          $display("FAIL %s dut%0d: LED_BCD=%h digits=%b, expected LED_BCD=%h digits=%b",
                   e.name, e.dut, led_o[e.dut], dig_o[e.dut], e.led, e.dig);
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; cnt[i] = 2'd0; bcd[i] = 16'h0000;
    end
    @(negedge clk);

    // Default instance: active-low, no blanking
    apply(0, 1'b1, 2'd0, 16'h1234, 4'h0, 4'b1111, "rst_default");
    apply(0, 1'b0, 2'd0, 16'h1234, 4'h4, 4'b1110, "scan_d0");
    apply(0, 1'b0, 2'd1, 16'h1234, 4'h3, 4'b1101, "scan_d1");
    apply(0, 1'b0, 2'd2, 16'h1234, 4'h2, 4'b1011, "scan_d2");
    apply(0, 1'b0, 2'd3, 16'h1234, 4'h1, 4'b0111, "scan_d3");
    apply(0, 1'b1, 2'd2, 16'h1234, 4'h0, 4'b1111, "rst_midscan");
    apply(0, 1'b0, 2'd2, 16'h1234, 4'h2, 4'b1011, "resume");
    apply(0, 1'b0, 2'd3, 16'hFA00, 4'hF, 4'b0111, "nonbcd_F");
    apply(0, 1'b0, 2'd2, 16'hFA00, 4'hA, 4'b1011, "nonbcd_A");
    apply(0, 1'b0, 2'd3, 16'h0045, 4'h0, 4'b0111, "no_blank_default");

    // Blanking instance
    apply(1, 1'b1, 2'd3, 16'h0045, 4'h0, 4'b1111, "rst_blank");
    apply(1, 1'b0, 2'd3, 16'h0045, 4'h0, 4'b1111, "blank_d3");
    apply(1, 1'b0, 2'd2, 16'h0045, 4'h0, 4'b1111, "blank_d2");
    apply(1, 1'b0, 2'd1, 16'h0045, 4'h4, 4'b1101, "shown_d1");
    apply(1, 1'b0, 2'd0, 16'h0045, 4'h5, 4'b1110, "shown_d0");
    apply(1, 1'b0, 2'd0, 16'h0000, 4'h0, 4'b1110, "d0_never_blank");
    apply(1, 1'b0, 2'd1, 16'h0000, 4'h0, 4'b1111, "blank_all_zero_d1");
    apply(1, 1'b0, 2'd1, 16'h0405, 4'h0, 4'b1101, "inner_zero_shown");
    apply(1, 1'b0, 2'd2, 16'h0405, 4'h4, 4'b1011, "d2_nonzero");
    apply(1, 1'b0, 2'd3, 16'h8000, 4'h8, 4'b0111, "d3_nonzero");

    // Active-high instance
    apply(2, 1'b1, 2'd2, 16'h1234, 4'h0, 4'b0000, "rst_active_high");
    apply(2, 1'b0, 2'd2, 16'h1234, 4'h2, 4'b0100, "ah_d2");
    apply(2, 1'b0, 2'd0, 16'h1234, 4'h4, 4'b0001, "ah_d0");
    apply(2, 1'b1, 2'd1, 16'h1234, 4'h0, 4'b0000, "ah_rst_again");
    apply(2, 1'b0, 2'd3, 16'h1234, 4'h1, 4'b1000, "ah_d3");

    stim_done = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses still queued, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL expose parameter DIGIT_ACTIVE_LOW, default 1: 1 = digit enables active-low (common-anode display), 0 = active-high.
REQ-002 The block SHALL expose parameter BLANK_LEADING, default 0: 1 = suppress leading-zero digits, 0 = always show all four digits.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port countout  input  2  scan index selecting which digit is driven this cycle.
REQ-006 Port BCD  input  16  four packed BCD digits: [3:0] digit 0 (least significant), [7:4] digit 1, [11:8] digit 2, [15:12] digit 3.
REQ-007 Port LED_BCD  output  4  registered nibble of the selected digit.
REQ-008 Port digits  output  4  registered one-hot digit enable; bit n enables digit n.

Function
REQ-009 On each rising clk edge with reset low, the block SHALL register the nibble and enable selected by countout; outputs SHALL reflect inputs with exactly one clk cycle of latency.
REQ-010 countout=00 SHALL select BCD[3:0] and enable digit 0.
REQ-011 countout=01 SHALL select BCD[7:4] and enable digit 1.
REQ-012 countout=10 SHALL select BCD[11:8] and enable digit 2.
REQ-013 countout=11 SHALL select BCD[15:12] and enable digit 3.
REQ-014 With DIGIT_ACTIVE_LOW=1, the enable patterns SHALL be 1110, 1101, 1011, 0111 for digits 0..3, and 1111 when all digits are off.
REQ-015 With DIGIT_ACTIVE_LOW=0, the enable patterns SHALL be 0001, 0010, 0100, 1000, and 0000 when all digits are off.
REQ-016 Exactly one digit SHALL be enabled per cycle, except in reset or when the digit is blanked.
REQ-017 Nibbles 1010-1111 (non-BCD) SHALL pass through to LED_BCD unchanged; no error flag.
REQ-018 With BLANK_LEADING=1, digit n (n=1..3) SHALL be blanked when it and every higher digit are 0000.
REQ-019 A blanked digit SHALL drive the all-off enable pattern and LED_BCD=0000.
REQ-020 Digit 0 SHALL never be blanked.
REQ-021 The datapath SHALL be purely combinational between the input ports and the output registers; there is no other state.

Reset
REQ-022 While reset is high at a rising clk edge, LED_BCD SHALL become 0000 and digits SHALL become the all-off pattern.
REQ-023 Reset SHALL override any countout or BCD change in the same cycle.
REQ-024 Normal operation SHALL resume on the first rising edge after reset deasserts, using the inputs sampled at that edge.

Structure
REQ-025 The shared package SHALL hold constants DIGIT_COUNT=4, NIBBLE_W=4, and the active-low enable pattern table (indexed by countout) together with the all-off pattern.
REQ-026 One sub-module, digit_mux, SHALL implement the combinational 4:1 nibble select plus the blank-condition logic; the top level SHALL hold the enable encoding, polarity handling and output registers.

Verification
REQ-027 BCD=16'h1234, countout 00,01,10,11 on successive cycles -> one cycle later LED_BCD=4,3,2,1 and digits=1110,1101,1011,0111.
REQ-028 Reset high mid-scan (countout=10) -> next edge LED_BCD=0000 and digits=1111; after reset drops with countout=10, the next edge gives LED_BCD=2, digits=1011.
REQ-029 BCD=16'hFA00 with countout=11, then countout=10 -> LED_BCD=F, then A; digits=0111, then 1011.
REQ-030 BLANK_LEADING=1, BCD=16'h0045, countout=11 then 10 -> digits=1111 and LED_BCD=0 both cycles; countout=01 -> LED_BCD=4, digits=1101.
REQ-031 BLANK_LEADING=1, BCD=16'h0000, countout=00 -> LED_BCD=0, digits=1110 (digit 0 never blanked).
REQ-032 DIGIT_ACTIVE_LOW=0, BCD=16'h1234, countout=10 -> digits=0100, LED_BCD=2; in reset, digits=0000.
